// File: rtl/sprite_rom_arbiter_if.sv
// Bus bundle between the sprite requesters / image BROM and the ROM read arbiter.
interface sprite_rom_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic [ADDR_WIDTH-1:0]         rom_addr_out;
    logic                          rom_en_out;
    logic [DATA_WIDTH-1:0]         rom_data_in;
    logic [NUM_REQ-1:0]            rsp_valid_out;
    logic [DATA_WIDTH-1:0]         rsp_data_out;
    logic [15:0]                   stall_count_out;

    // Arbiter side
    modport slave (
        input  req_valid_in,
        input  req_addr_in,
        input  rom_data_in,
        output req_ready_out,
        output rom_addr_out,
        output rom_en_out,
        output rsp_valid_out,
        output rsp_data_out,
        output stall_count_out
    );

    // Requester / BROM side
    modport master (
        output req_valid_in,
        output req_addr_in,
        output rom_data_in,
        input  req_ready_out,
        input  rom_addr_out,
        input  rom_en_out,
        input  rsp_valid_out,
        input  rsp_data_out,
        input  stall_count_out
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one fixed-latency image BROM among sprite requesters.
// Grants are combinational in the request cycle; a tag pipeline routes each
// returned word back to the requester that issued the read.
module sprite_rom_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_WIDTH   = 17,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_in,
    sprite_rom_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STALL_W = 16;

    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]    tag [READ_LATENCY];
    logic [STALL_W-1:0]    stall_cnt;

    logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic                  grant_any;
    logic [PTR_W-1:0]      grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [PTR_W-1:0]      ptr_nxt;
    logic                  stall_hit;

    // Unpack the flat requester address bus
    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_addr
        assign req_addr[g] = bus.req_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Search from rr_ptr upward with wrap; first valid requester wins
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_addr = '0;
        sum        = '0;
        idx        = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = PTR_W'(sum);
            if (!grant_any && bus.req_valid_in[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
                grant_addr = req_addr[idx];
            end
        end
        if (rst_in) begin
            grant      = '0;
            grant_any  = 1'b0;
            grant_addr = '0;
        end
    end

    // Next pointer sits just past the winner; contention when any valid is not granted
    always_comb begin
        ptr_nxt = '0;
        if (grant_idx != PTR_W'(NUM_REQ - 1)) begin
            ptr_nxt = grant_idx + 1'b1;
        end
        stall_hit = |(bus.req_valid_in & ~grant);
    end

    // Pointer, in-flight tag pipeline and saturating stall counter
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rr_ptr    <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < int'(READ_LATENCY); k++) begin
                tag[k] <= '0;
            end
        end else begin
            if (grant_any) begin
                rr_ptr <= ptr_nxt;
            end
            tag[0] <= grant;
            for (int k = 1; k < int'(READ_LATENCY); k++) begin
                tag[k] <= tag[k-1];
            end
            if (stall_hit && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.req_ready_out   = grant;
    assign bus.rom_en_out      = grant_any;
    assign bus.rom_addr_out    = grant_addr;
    assign bus.rsp_valid_out   = tag[READ_LATENCY-1];
    assign bus.rsp_data_out    = (|tag[READ_LATENCY-1]) ? bus.rom_data_in : '0;
    assign bus.stall_count_out = stall_cnt;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: BROM model (latency 2, mem[a] = a[7:0]^8'h5A),
// per-cycle comparison against a queue-based behavioural model, plus literal pins.
module tb_sprite_rom_arbiter;
    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned ADDR_WIDTH   = 17;
    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned READ_LATENCY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_rom_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) bus ();

    sprite_rom_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    function automatic logic [7:0] rom_f(input logic [16:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Image BROM: two-stage read pipeline, unaffected by the arbiter's reset
    logic [7:0] rom_p1 = 8'h00;
    logic [7:0] rom_p2 = 8'h00;
    always @(posedge clk) begin
        rom_p1 <= rom_f(bus.rom_addr_out);
        rom_p2 <= rom_p1;
    end
    assign bus.rom_data_in = rom_p2;

    logic [3:0]  valid = 4'b0000;
    logic [16:0] addr [4];
    assign bus.req_valid_in = valid;
    assign bus.req_addr_in  = {addr[3], addr[2], addr[1], addr[0]};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: pointer, outstanding-response list with due cycles, stall tally
    typedef struct {
        int         due;
        logic [3:0] who;
        logic [7:0] data;
    } rsp_t;
    rsp_t m_q[$];
    int   m_ptr   = 0;
    int   m_stall = 0;
    int   m_cycle = 0;

    logic [3:0]  s_ready, s_rsp;
    logic [7:0]  s_data;
    logic [15:0] s_stall;
    logic        s_en;
    logic [16:0] s_addr;

    // One pixel clock: sample mid-cycle, compare every output to the model, advance the model
    task automatic step();
        logic [3:0] eg;
        logic [3:0] er;
        logic [7:0] ed;
        int gi;
        int i;
        @(negedge clk);
        s_ready = bus.req_ready_out;
        s_rsp   = bus.rsp_valid_out;
        s_data  = bus.rsp_data_out;
        s_stall = bus.stall_count_out;
        s_en    = bus.rom_en_out;
        s_addr  = bus.rom_addr_out;

        eg = 4'b0000;
        gi = 0;
        if (!rst) begin
            for (int off = 0; off < 4; off++) begin
                i = (m_ptr + off) % 4;
                if (eg == 4'b0000 && valid[i]) begin
                    eg[i] = 1'b1;
                    gi    = i;
                end
            end
        end
        er = 4'b0000;
        ed = 8'h00;
        if (m_q.size() > 0 && m_q[0].due == m_cycle) begin
            er = m_q[0].who;
            ed = m_q[0].data;
            void'(m_q.pop_front());
        end

        chk("ready",     32'(s_ready), 32'(eg));
        chk("rom_en",    32'(s_en),    32'(eg != 4'b0000));
        chk("rom_addr",  32'(s_addr),  (eg != 4'b0000) ? 32'(addr[gi]) : 32'd0);
        chk("rsp_valid", 32'(s_rsp),   32'(er));
        chk("rsp_data",  32'(s_data),  32'(ed));
        chk("stall",     32'(s_stall), 32'(m_stall));

        if (rst) begin
            m_ptr   = 0;
            m_stall = 0;
            m_q.delete();
        end else begin
            if (eg != 4'b0000) begin
                m_ptr = (gi + 1) % 4;
                m_q.push_back('{m_cycle + int'(READ_LATENCY), eg, rom_f(addr[gi])});
            end
            if ((valid & ~eg) != 4'b0000 && m_stall < 65535) m_stall++;
        end
        m_cycle++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        addr[0] = 17'h00123;
        addr[1] = 17'h10045;
        addr[2] = 17'h00010;
        addr[3] = 17'h0ABFF;
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        chk("reset_ready", 32'(s_ready), 32'd0);
        chk("reset_stall", 32'(s_stall), 32'd0);
        step();
        rst = 1'b0;

        // Single active requester: granted every cycle, data after two cycles
        valid = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t1_ready", 32'(s_ready), 32'h4);
            if (k >= 3) begin
                chk("t1_rsp_valid", 32'(s_rsp), 32'h4);
                chk("t1_rsp_data",  32'(s_data), 32'h4A);
            end
        end
        valid = 4'b0000;
        repeat (3) step();

        // All four requesting from reset: strict rotation, one stall per cycle
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_grant", 32'(s_ready), 32'(4'b0001 << (k % 4)));
        end
        step();
        chk("t2_stall8", 32'(s_stall), 32'd8);

        // Pointer at 2 after granting 1; reqs 1 and 3 alternate starting with 3
        valid = 4'b0010;
        step();
        chk("t3_pre", 32'(s_ready), 32'h2);
        valid = 4'b1010;
        step();
        chk("t3_g3a", 32'(s_ready), 32'h8);
        step();
        chk("t3_g1",  32'(s_ready), 32'h2);
        step();
        chk("t3_g3b", 32'(s_ready), 32'h8);

        // Reset right after a grant discards the in-flight read
        valid = 4'b0001;
        step();
        chk("t4_grant0", 32'(s_ready), 32'h1);
        valid = 4'b0000;
        rst = 1'b1;
        step();
        step();
        chk("t4_rsp_n2",  32'(s_rsp),  32'd0);
        chk("t4_data_n2", 32'(s_data), 32'd0);
        rst = 1'b0;
        valid = 4'b1001;
        step();
        chk("t4_rsp_n3", 32'(s_rsp),   32'd0);
        chk("t4_ptr0",   32'(s_ready), 32'h1);
        valid = 4'b1000;
        step();
        chk("t4_req3", 32'(s_ready), 32'h8);
        valid = 4'b0000;
        repeat (3) step();

        // Long contention saturates the stall counter
        valid = 4'b0011;
        repeat (65540) step();
        chk("t5_sat", 32'(s_stall), 32'hFFFF);
        step();
        chk("t5_hold", 32'(s_stall), 32'hFFFF);

        // Idle: nothing issued, counter and pointer hold
        valid = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t6_en",    32'(s_en),    32'd0);
            chk("t6_addr",  32'(s_addr),  32'd0);
            chk("t6_stall", 32'(s_stall), 32'hFFFF);
            if (k >= 3) chk("t6_rsp", 32'(s_rsp), 32'd0);
        end
        valid = 4'b1111;
        step();
        chk("t6_ptr_held", 32'(s_ready), 32'h2);
        valid = 4'b0000;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
